// File: rtl/reg_arbiter_if.sv
// Shared register-bus bundle: two masters, one slave-side bus, plus arbiter status.
// The arbiter connects through 'slave' (it serves the masters); the environment uses 'master'.
interface reg_arbiter_if;
    logic [13:0] m0_reg_addr;
    logic        m0_reg_rd;
    logic        m0_reg_wr;
    logic [31:0] m0_reg_writedata;
    logic        m0_reg_ready;
    logic [31:0] m0_reg_readdata;

    logic [13:0] m1_reg_addr;
    logic        m1_reg_rd;
    logic        m1_reg_wr;
    logic [31:0] m1_reg_writedata;
    logic        m1_reg_ready;
    logic [31:0] m1_reg_readdata;

    logic [13:0] reg_addr;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_writedata;
    logic        reg_ready;
    logic [31:0] reg_readdata;

    logic [1:0]  grant;
    logic [15:0] timeout_cnt;

    modport slave (
        input  m0_reg_addr, m0_reg_rd, m0_reg_wr, m0_reg_writedata,
        input  m1_reg_addr, m1_reg_rd, m1_reg_wr, m1_reg_writedata,
        output m0_reg_ready, m0_reg_readdata, m1_reg_ready, m1_reg_readdata,
        output reg_addr, reg_rd, reg_wr, reg_writedata,
        input  reg_ready, reg_readdata,
        output grant, timeout_cnt
    );

    modport master (
        output m0_reg_addr, m0_reg_rd, m0_reg_wr, m0_reg_writedata,
        output m1_reg_addr, m1_reg_rd, m1_reg_wr, m1_reg_writedata,
        input  m0_reg_ready, m0_reg_readdata, m1_reg_ready, m1_reg_readdata,
        input  reg_addr, reg_rd, reg_wr, reg_writedata,
        output reg_ready, reg_readdata,
        input  grant, timeout_cnt
    );
endinterface

// File: rtl/reg_arbiter.sv
// Round-robin two-master register-bus arbiter with a mandatory IDLE cycle between grants
// and a per-access timeout that completes a stuck access with BAD_WORD.
module reg_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] BAD_WORD = 32'h0BAD0BAD
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [9:0]  wait_q, wait_d;
    logic [15:0] tcnt_q, tcnt_d;

    logic        req0, req1, own1;
    logic        o_req, o_rd, o_wr;
    logic [13:0] o_addr;
    logic [31:0] o_wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic [13:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd, bus_wr;

    assign req0 = bus.m0_reg_rd | bus.m0_reg_wr;
    assign req1 = bus.m1_reg_rd | bus.m1_reg_wr;
    assign own1 = (state_q == OWN1);

    assign o_req   = own1 ? req1                 : req0;
    assign o_rd    = own1 ? bus.m1_reg_rd        : bus.m0_reg_rd;
    assign o_wr    = own1 ? bus.m1_reg_wr        : bus.m0_reg_wr;
    assign o_addr  = own1 ? bus.m1_reg_addr      : bus.m0_reg_addr;
    assign o_wdata = own1 ? bus.m1_reg_writedata : bus.m0_reg_writedata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wait_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wait_d    = wait_q;
        tcnt_d    = tcnt_q;
        rdy       = 1'b0;
        rdata     = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                // last_q == 1 means m1 was served last, so m0 wins a tie
                if (req0 && (!req1 || last_q)) state_d = OWN0;
                else if (req1)                  state_d = OWN1;
            end
            OWN0, OWN1: begin
                bus_addr  = o_addr;
                bus_wdata = o_wdata;
                bus_wr    = o_wr;
                bus_rd    = o_rd & ~o_wr;
                if (!o_req) begin
                    state_d = IDLE;
                end else if (bus.reg_ready) begin
                    rdy     = 1'b1;
                    rdata   = bus.reg_readdata;
                    state_d = IDLE;
                    last_d  = own1;
                end else if (wait_q == TIMEOUT_W) begin
                    rdy     = 1'b1;
                    rdata   = BAD_WORD;
                    bus_rd  = 1'b0;
                    bus_wr  = 1'b0;
                    tcnt_d  = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
                    state_d = IDLE;
                    last_d  = own1;
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.reg_addr        = bus_addr;
    assign bus.reg_writedata   = bus_wdata;
    assign bus.reg_rd          = bus_rd;
    assign bus.reg_wr          = bus_wr;
    assign bus.m0_reg_ready    = rdy & ~own1;
    assign bus.m1_reg_ready    = rdy &  own1;
    assign bus.m0_reg_readdata = own1 ? 32'h0 : rdata;
    assign bus.m1_reg_readdata = own1 ? rdata : 32'h0;
    assign bus.grant           = {state_q == OWN1, state_q == OWN0};
    assign bus.timeout_cnt     = tcnt_q;
endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter (TIMEOUT = 4); inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_reg_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    reg_arbiter_if bus ();

    reg_arbiter #(.TIMEOUT(4), .BAD_WORD(32'h0BAD0BAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.m0_reg_addr = '0; bus.m0_reg_rd = 0; bus.m0_reg_wr = 0; bus.m0_reg_writedata = '0;
        bus.m1_reg_addr = '0; bus.m1_reg_rd = 0; bus.m1_reg_wr = 0; bus.m1_reg_writedata = '0;
        bus.reg_ready = 0; bus.reg_readdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.m0_reg_rd = 1; bus.m0_reg_addr = 14'h0ABC;
        bus.reg_ready = 1; bus.reg_readdata = 32'hDEADBEEF;
        rst_n = 0;
        #1;
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
        checks++; if (bus.m0_reg_ready !== 1'b0 || bus.m1_reg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", bus.m1_reg_ready, bus.m0_reg_ready); end
        checks++; if (bus.m0_reg_readdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.m0_reg_readdata); end
        checks++; if (bus.reg_rd !== 1'b0 || bus.reg_addr !== 14'h0) begin failures++; $display("FAIL reset_bus got rd=%b addr=%h exp 0", bus.reg_rd, bus.reg_addr); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.grant !== 2'b00 || bus.timeout_cnt !== 16'h0) begin failures++; $display("FAIL reset_hold got grant=%b tcnt=%h exp 0", bus.grant, bus.timeout_cnt); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic exp_on;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin bus.m0_reg_rd = 1; bus.m0_reg_addr = 14'h00FF; end
            if (c == 4) begin bus.reg_ready = 1; bus.reg_readdata = 32'h00050003; end
            if (c == 5) clear_inputs();
            #1;
            exp_on = (c >= 1 && c <= 4);
            checks++; if (bus.grant !== (exp_on ? 2'b01 : 2'b00)) begin failures++; $display("FAIL rd_grant c=%0d got=%b exp_on=%b", c, bus.grant, exp_on); end
            checks++; if (bus.reg_rd !== exp_on || bus.reg_wr !== 1'b0) begin failures++; $display("FAIL rd_regrd c=%0d got rd=%b wr=%b exp rd=%b", c, bus.reg_rd, bus.reg_wr, exp_on); end
            checks++; if (bus.reg_addr !== (exp_on ? 14'h00FF : 14'h0)) begin failures++; $display("FAIL rd_addr c=%0d got=%h", c, bus.reg_addr); end
            checks++; if (bus.m0_reg_ready !== (c == 4) || bus.m1_reg_ready !== 1'b0) begin failures++; $display("FAIL rd_ready c=%0d got m0=%b m1=%b", c, bus.m0_reg_ready, bus.m1_reg_ready); end
            checks++; if (bus.m0_reg_readdata !== ((c == 4) ? 32'h00050003 : 32'h0)) begin failures++; $display("FAIL rd_rdata c=%0d got=%h", c, bus.m0_reg_readdata); end
        end
    endtask

    task automatic test_ready_boundary();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 0) begin bus.m0_reg_rd = 1; bus.m0_reg_addr = 14'h0123; end
            if (c == 5) begin bus.reg_ready = 1; bus.reg_readdata = 32'hCAFE0001; end
            if (c == 6) clear_inputs();
            #1;
            checks++; if (bus.grant !== ((c >= 1 && c <= 5) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL bnd_grant c=%0d got=%b", c, bus.grant); end
            checks++; if (bus.m0_reg_ready !== (c == 5)) begin failures++; $display("FAIL bnd_ready c=%0d got=%b exp=%b", c, bus.m0_reg_ready, (c == 5)); end
            if (c == 5) begin
                checks++; if (bus.m0_reg_readdata !== 32'hCAFE0001) begin failures++; $display("FAIL bnd_rdata got=%h exp=cafe0001", bus.m0_reg_readdata); end
                checks++; if (bus.reg_rd !== 1'b1) begin failures++; $display("FAIL bnd_regrd got=%b exp=1", bus.reg_rd); end
            end
        end
        checks++; if (bus.timeout_cnt !== 16'h0) begin failures++; $display("FAIL bnd_tcnt got=%h exp=0", bus.timeout_cnt); end
    endtask

    task automatic test_timeout();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 0) begin bus.m1_reg_rd = 1; bus.m1_reg_addr = 14'h0100; end
            if (c == 6) clear_inputs();
            #1;
            checks++; if (bus.grant !== ((c >= 1 && c <= 5) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL to_grant c=%0d got=%b", c, bus.grant); end
            checks++; if (bus.reg_rd !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL to_regrd c=%0d got=%b", c, bus.reg_rd); end
            checks++; if (bus.m1_reg_ready !== (c == 5) || bus.m0_reg_ready !== 1'b0) begin failures++; $display("FAIL to_ready c=%0d got m1=%b m0=%b", c, bus.m1_reg_ready, bus.m0_reg_ready); end
            checks++; if (bus.m1_reg_readdata !== ((c == 5) ? 32'h0BAD0BAD : 32'h0)) begin failures++; $display("FAIL to_rdata c=%0d got=%h", c, bus.m1_reg_readdata); end
            checks++; if (bus.timeout_cnt !== ((c == 6) ? 16'd1 : 16'd0)) begin failures++; $display("FAIL to_tcnt c=%0d got=%h", c, bus.timeout_cnt); end
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [0:8];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.m0_reg_wr = 1; bus.m0_reg_rd = 1; bus.m0_reg_addr = 14'h0011; bus.m0_reg_writedata = 32'hAAAA0000;
                bus.m1_reg_wr = 1; bus.m1_reg_addr = 14'h0022; bus.m1_reg_writedata = 32'hBBBB1111;
                bus.reg_ready = 1;
            end
            if (c == 8) clear_inputs();
            #1;
            checks++; if (bus.grant !== exp_g[c]) begin failures++; $display("FAIL ct_grant c=%0d got=%b exp=%b", c, bus.grant, exp_g[c]); end
            checks++; if (bus.m0_reg_ready !== exp_g[c][0] || bus.m1_reg_ready !== exp_g[c][1]) begin failures++; $display("FAIL ct_ready c=%0d got m1m0=%b%b exp=%b", c, bus.m1_reg_ready, bus.m0_reg_ready, exp_g[c]); end
            checks++; if (bus.reg_wr !== (exp_g[c] != 2'b00) || bus.reg_rd !== 1'b0) begin failures++; $display("FAIL ct_wr c=%0d got wr=%b rd=%b", c, bus.reg_wr, bus.reg_rd); end
            checks++; if (bus.reg_addr !== (exp_g[c] == 2'b01 ? 14'h0011 : exp_g[c] == 2'b10 ? 14'h0022 : 14'h0)) begin failures++; $display("FAIL ct_addr c=%0d got=%h", c, bus.reg_addr); end
            checks++; if (bus.reg_writedata !== (exp_g[c] == 2'b01 ? 32'hAAAA0000 : exp_g[c] == 2'b10 ? 32'hBBBB1111 : 32'h0)) begin failures++; $display("FAIL ct_wdata c=%0d got=%h", c, bus.reg_writedata); end
        end
    endtask

    task automatic test_abort_and_reset();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin bus.m0_reg_rd = 1; bus.m0_reg_addr = 14'h0033; end
            if (c == 3) bus.m0_reg_rd = 0;
            if (c == 4) begin bus.m1_reg_wr = 1; bus.m1_reg_addr = 14'h0044; bus.m1_reg_writedata = 32'h12345678; end
            #1;
            checks++; if (bus.grant !== ((c >= 1 && c <= 3) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL ab_grant c=%0d got=%b", c, bus.grant); end
            checks++; if (bus.m0_reg_ready !== 1'b0 || bus.m1_reg_ready !== 1'b0) begin failures++; $display("FAIL ab_ready c=%0d got m1m0=%b%b exp=00", c, bus.m1_reg_ready, bus.m0_reg_ready); end
            checks++; if (bus.reg_rd !== (c == 1 || c == 2)) begin failures++; $display("FAIL ab_regrd c=%0d got=%b", c, bus.reg_rd); end
        end
        checks++; if (bus.reg_wr !== 1'b1 || bus.reg_writedata !== 32'h12345678) begin failures++; $display("FAIL ab_m1wr got wr=%b data=%h", bus.reg_wr, bus.reg_writedata); end
        #2;
        rst_n = 0;
        bus.reg_ready = 1; bus.reg_readdata = 32'h55AA55AA;
        bus.m0_reg_wr = 1; bus.m0_reg_addr = 14'h0055;
        #1;
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL rst_grant got=%b exp=00", bus.grant); end
        checks++; if (bus.m0_reg_ready !== 1'b0 || bus.m1_reg_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got m1m0=%b%b exp=00", bus.m1_reg_ready, bus.m0_reg_ready); end
        checks++; if (bus.m0_reg_readdata !== 32'h0 || bus.m1_reg_readdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got m0=%h m1=%h exp 0", bus.m0_reg_readdata, bus.m1_reg_readdata); end
        checks++; if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0 || bus.reg_addr !== 14'h0 || bus.reg_writedata !== 32'h0) begin failures++; $display("FAIL rst_bus got wr=%b rd=%b addr=%h wd=%h", bus.reg_wr, bus.reg_rd, bus.reg_addr, bus.reg_writedata); end
        checks++; if (bus.timeout_cnt !== 16'h0) begin failures++; $display("FAIL rst_tcnt got=%h exp=0", bus.timeout_cnt); end
        @(negedge clk);
        #1;
        checks++; if (bus.grant !== 2'b00 || bus.m1_reg_ready !== 1'b0) begin failures++; $display("FAIL rst_held got grant=%b m1rdy=%b", bus.grant, bus.m1_reg_ready); end
        bus.reg_ready = 0;
        rst_n = 1;
        @(negedge clk);
        #1;
        checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL post_rst_grant got=%b exp=01", bus.grant); end
        checks++; if (bus.reg_addr !== 14'h0055 || bus.reg_wr !== 1'b1) begin failures++; $display("FAIL post_rst_bus got addr=%h wr=%b", bus.reg_addr, bus.reg_wr); end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1;
        test_reset();
        test_single_read();
        test_ready_boundary();
        test_timeout();
        test_contention();
        test_abort_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
